// File: rtl/mem_access_ctrl_if.sv
`default_nettype none
// ============================================================================
//  mem_access_ctrl_if
//  Core request/response, program-counter and memory bus bundle.
//  Revision: 1.0
// ============================================================================
interface mem_access_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int ADR_W  = 5
);
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [ADR_W-1:0]  req_adr;
    logic [DATA_W-1:0] req_wdata;
    logic              pc_load;
    logic [ADR_W-1:0]  pc_value;
    logic [ADR_W-1:0]  pc;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_data;
    logic              resp_err;
    logic              mem_read;
    logic              mem_write;
    logic [ADR_W-1:0]  adr;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] read_data;

    // Core plus memory side
    modport master (
        output req_valid, req_op, req_adr, req_wdata, pc_load, pc_value, read_data,
        input  req_ready, pc, resp_valid, resp_data, resp_err,
               mem_read, mem_write, adr, write_data
    );

    // Controller side
    modport slave (
        input  req_valid, req_op, req_adr, req_wdata, pc_load, pc_value, read_data,
        output req_ready, pc, resp_valid, resp_data, resp_err,
               mem_read, mem_write, adr, write_data
    );
endinterface
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
//  mem_access_ctrl
//  Three-state (IDLE/ACCESS/RESP) fetch/load/store controller with PC.
//  Revision: 1.0
// ============================================================================
module mem_access_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADR_W  = 5
) (
    input  wire logic        clk,
    input  wire logic        rst,
    mem_access_ctrl_if.slave bus
);
    localparam logic [1:0] c_OP_FETCH   = 2'b00;
    localparam logic [1:0] c_OP_LOAD    = 2'b01;
    localparam logic [1:0] c_OP_STORE   = 2'b10;
    localparam logic [1:0] c_OP_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              w_accept;
    logic [1:0]        r_op;
    logic [ADR_W-1:0]  r_pc;
    logic              r_mem_read;
    logic              r_mem_write;
    logic [ADR_W-1:0]  r_adr;
    logic [DATA_W-1:0] r_write_data;
    logic [DATA_W-1:0] r_resp_data;

    assign w_accept = (r_state == IDLE) && bus.req_valid;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = (bus.req_op == c_OP_ILLEGAL) ? RESP : ACCESS;
            ACCESS:  w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_op         <= c_OP_FETCH;
            r_pc         <= '0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_adr        <= '0;
            r_write_data <= '0;
            r_resp_data  <= '0;
        end else begin
            r_state     <= w_next;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;

            if (w_accept) begin
                r_op <= bus.req_op;
                case (bus.req_op)
                    // A same-edge pc_load redirects the fetch to the new PC
                    c_OP_FETCH: begin
                        r_mem_read <= 1'b1;
                        r_adr      <= bus.pc_load ? bus.pc_value : r_pc;
                    end
                    c_OP_LOAD: begin
                        r_mem_read <= 1'b1;
                        r_adr      <= bus.req_adr;
                    end
                    c_OP_STORE: begin
                        r_mem_write  <= 1'b1;
                        r_adr        <= bus.req_adr;
                        r_write_data <= bus.req_wdata;
                    end
                    default: ;
                endcase
            end

            // Memory presents read_data on the falling edge inside ACCESS
            if (r_state == ACCESS && (r_op == c_OP_FETCH || r_op == c_OP_LOAD))
                r_resp_data <= bus.read_data;

            // An explicit pc_load always wins over the fetch increment
            if (bus.pc_load)
                r_pc <= bus.pc_value;
            else if (r_state == ACCESS && r_op == c_OP_FETCH)
                r_pc <= r_pc + ADR_W'(1);
        end
    end

    assign bus.req_ready  = (r_state == IDLE);
    assign bus.resp_valid = (r_state == RESP);
    assign bus.resp_err   = (r_state == RESP) && (r_op == c_OP_ILLEGAL);
    assign bus.resp_data  = r_resp_data;
    assign bus.pc         = r_pc;
    assign bus.mem_read   = r_mem_read;
    assign bus.mem_write  = r_mem_write;
    assign bus.adr        = r_adr;
    assign bus.write_data = r_write_data;
endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
//  tb_mem_access_ctrl
//  Directed literal checks plus randomized traffic against a timeline model.
//  Revision: 1.0
// ============================================================================
module tb_mem_access_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic [1:0] req_op = 2'b00;
    logic [4:0] req_adr = '0;
    logic [7:0] req_wdata = '0;
    logic       pc_load = 1'b0;
    logic [4:0] pc_value = '0;

    int pass_cnt = 0;
    int total_cnt = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    mem_access_ctrl_if #(.DATA_W(8), .ADR_W(5)) bus ();

    assign bus.req_valid = req_valid;
    assign bus.req_op    = req_op;
    assign bus.req_adr   = req_adr;
    assign bus.req_wdata = req_wdata;
    assign bus.pc_load   = pc_load;
    assign bus.pc_value  = pc_value;

    mem_access_ctrl #(.DATA_W(8), .ADR_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Environment memory: responds on the falling edge
    logic [7:0] mem [32];
    always @(negedge clk) begin
        if (bus.mem_write) mem[bus.adr] = bus.write_data;
        if (bus.mem_read)  bus.read_data <= mem[bus.adr];
    end

    // Timeline model: each accepted request fixes when its strobe, response
    // and next ready happen, counted in rising edges.
    logic [7:0] ref_mem [32];
    int         t = 0;
    int         acc_t = -100;
    int         free_t = 0;
    logic [1:0] acc_op = 2'b00;
    logic [7:0] acc_rd = '0;
    logic [4:0] m_pc = '0;
    logic [4:0] old_pc = '0;
    logic [7:0] m_data = '0;
    logic [4:0] e_adr = '0;
    logic [7:0] e_wd = '0;

    always @(posedge clk) begin
        t = t + 1;
        if (rst) begin
            m_pc = '0; m_data = '0; e_adr = '0; e_wd = '0;
            acc_t = -100; free_t = 0;
        end else begin
            old_pc = m_pc;
            if (acc_t == t - 1 && acc_op != 2'b11) begin
                if (acc_op != 2'b10) m_data = acc_rd;
                if (acc_op == 2'b00) m_pc = m_pc + 5'd1;
            end
            if (pc_load) m_pc = pc_value;
            if (req_valid && t >= free_t) begin
                acc_t  = t;
                acc_op = req_op;
                free_t = (req_op == 2'b11) ? t + 2 : t + 3;
                case (req_op)
                    2'b00: begin e_adr = pc_load ? pc_value : old_pc; acc_rd = ref_mem[e_adr]; end
                    2'b01: begin e_adr = req_adr; acc_rd = ref_mem[req_adr]; end
                    2'b10: begin e_adr = req_adr; e_wd = req_wdata; ref_mem[req_adr] = req_wdata; end
                    default: ;
                endcase
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0d)", name, act, exp, t);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("req_ready",  int'(bus.req_ready),  int'(t + 1 >= free_t));
            check("mem_read",   int'(bus.mem_read),   int'(acc_t == t && (acc_op == 2'b00 || acc_op == 2'b01)));
            check("mem_write",  int'(bus.mem_write),  int'(acc_t == t && acc_op == 2'b10));
            check("resp_valid", int'(bus.resp_valid),
                  int'((acc_op != 2'b11 && acc_t == t - 1) || (acc_op == 2'b11 && acc_t == t)));
            check("resp_err",   int'(bus.resp_err),   int'(acc_op == 2'b11 && acc_t == t));
            check("pc",         int'(bus.pc),         int'(m_pc));
            check("resp_data",  int'(bus.resp_data),  int'(m_data));
            check("adr",        int'(bus.adr),        int'(e_adr));
            check("write_data", int'(bus.write_data), int'(e_wd));
            check("dual_strobe", int'(bus.mem_read & bus.mem_write), 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [1:0] op, input logic [4:0] a, input logic [7:0] d);
        req_valid = 1'b1; req_op = op; req_adr = a; req_wdata = d;
        tick();
        req_valid = 1'b0;
    endtask

    initial begin
        int cnt;
        for (int i = 0; i < 32; i++) begin
            mem[i] = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        mem[0] = 8'h92; ref_mem[0] = 8'h92;
        bus.read_data = '0;

        tick(); tick();
        check("rst_pc", int'(bus.pc), 0);
        check("rst_ready", int'(bus.req_ready), 1);
        check("rst_resp_valid", int'(bus.resp_valid), 0);
        check("rst_adr", int'(bus.adr), 0);
        check("rst_resp_data", int'(bus.resp_data), 0);
        chk_en = 1'b1;
        rst = 1'b0;

        // Fetch from address 0
        req(2'b00, 5'd0, 8'h00);
        check("fetch_strobe", int'(bus.mem_read), 1);
        check("fetch_adr", int'(bus.adr), 0);
        tick();
        check("fetch_resp_valid", int'(bus.resp_valid), 1);
        check("fetch_data", int'(bus.resp_data), 'h92);
        check("fetch_pc", int'(bus.pc), 1);
        tick();

        // Store then load back
        req(2'b10, 5'd22, 8'h3C);
        check("store_strobe", int'(bus.mem_write), 1);
        check("store_adr", int'(bus.adr), 22);
        check("store_wdata", int'(bus.write_data), 'h3C);
        tick(); tick();
        req(2'b01, 5'd22, 8'h00);
        tick();
        check("load_data", int'(bus.resp_data), 'h3C);
        check("load_pc", int'(bus.pc), 1);
        tick();

        // Illegal op
        req(2'b11, 5'd3, 8'hFF);
        check("ill_resp_valid", int'(bus.resp_valid), 1);
        check("ill_resp_err", int'(bus.resp_err), 1);
        check("ill_no_strobe", int'(bus.mem_read | bus.mem_write), 0);
        check("ill_data_held", int'(bus.resp_data), 'h3C);
        tick();

        // PC wrap
        pc_load = 1'b1; pc_value = 5'd31;
        tick();
        pc_load = 1'b0;
        check("pcload_pc", int'(bus.pc), 31);
        req(2'b00, 5'd0, 8'h00);
        check("wrap_adr0", int'(bus.adr), 31);
        tick();
        check("wrap_pc0", int'(bus.pc), 0);
        tick();
        req(2'b00, 5'd0, 8'h00);
        check("wrap_adr1", int'(bus.adr), 0);
        tick();
        check("wrap_pc1", int'(bus.pc), 1);
        tick();

        // Reset during the ACCESS cycle of a load
        req(2'b01, 5'd5, 8'h00);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_strobe", int'(bus.mem_read), 0);
        check("abort_resp", int'(bus.resp_valid), 0);
        check("abort_ready", int'(bus.req_ready), 1);
        check("abort_pc", int'(bus.pc), 0);
        tick();
        check("abort_resp_late", int'(bus.resp_valid), 0);

        // Back-to-back fetches with req_valid held high
        cnt = 0;
        req_valid = 1'b1; req_op = 2'b00;
        for (int i = 0; i < 9; i++) begin
            tick();
            if (bus.mem_read) cnt++;
        end
        req_valid = 1'b0;
        check("b2b_accepts", cnt, 3);
        tick(); tick();

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            rst       = ($urandom_range(0, 49) == 0);
            req_valid = 1'($urandom_range(0, 1));
            req_op    = 2'($urandom_range(0, 3));
            req_adr   = 5'($urandom_range(0, 31));
            req_wdata = 8'($urandom);
            pc_load   = ($urandom_range(0, 7) == 0);
            pc_value  = 5'($urandom_range(0, 31));
            tick();
        end
        rst = 1'b0; req_valid = 1'b0; pc_load = 1'b0;
        tick(); tick(); tick(); tick();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
`default_nettype wire
